// File: rtl/alu_op_sequencer.sv
// Multi-cycle READ/EXEC/WB controller for register file + write mux + ALU, with host load-port arbitration.
// Optional op counter (Op_Count / Op_Count_Clr) enabled by defining ALU_SEQ_PERF_CNT_EN.
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic [OP_W-1:0]   Cmd_Op,
  input  logic [REG_AW-1:0] Cmd_Rs,
  input  logic [REG_AW-1:0] Cmd_Rt,
  input  logic [REG_AW-1:0] Cmd_Rd,
  input  logic [4:0]        Cmd_Shamt,
  input  logic              Cmd_WbEn,
  input  logic              Ld_Valid,
  output logic              Ld_Ready,
  input  logic [REG_AW-1:0] Ld_Addr,
  input  logic [DATA_W-1:0] Ld_Data,
  output logic [REG_AW-1:0] RR1,
  output logic [REG_AW-1:0] RR2,
  output logic              WE,
  output logic [REG_AW-1:0] WR,
  output logic [DATA_W-1:0] WD,
  output logic              Mux_Ctrl,
  output logic [OP_W-1:0]   Alu_Op,
  output logic [4:0]        Alu_Shift,
  input  logic [DATA_W-1:0] Alu_Result,
  input  logic              Alu_Zero,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Done_Result,
  output logic              Done_Zero,
  output logic              Done_Err
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  input  logic              Op_Count_Clr,
  output logic [15:0]       Op_Count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam logic [OP_W-1:0] OP_MAX = OP_W'(8);

  state_t              state, state_next;
  logic [OP_W-1:0]     op_q;
  logic [REG_AW-1:0]   rs_q, rt_q, rd_q;
  logic [4:0]          shamt_q;
  logic                wben_q;

  logic                op_legal;
  logic                cmd_fire;
  logic                ld_fire;
  logic                wb_active;
  logic                operand_hit;

  assign op_legal  = (op_q <= OP_MAX);
  assign cmd_fire  = Cmd_Valid && Cmd_Ready;
  assign wb_active = (state == S_WB) && wben_q && op_legal;

  // A load may not overwrite an operand between latch and ALU evaluation.
  assign operand_hit = ((state == S_READ) || (state == S_EXEC)) &&
                       ((Ld_Addr == rs_q) || (Ld_Addr == rt_q));

  assign Cmd_Ready = Rst_n && ((state == S_IDLE) || (state == S_WB));
  assign Ld_Ready  = Rst_n && !wb_active && !operand_hit;
  assign ld_fire   = Ld_Valid && Ld_Ready;

  assign RR1       = rs_q;
  assign RR2       = rt_q;
  assign Alu_Op    = op_q;
  assign Alu_Shift = shamt_q;
  assign Busy      = (state != S_IDLE);
  assign Done      = (state == S_WB);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    WE         = 1'b0;
    WR         = '0;
    WD         = '0;
    Mux_Ctrl   = 1'b0;
    unique case (state)
      S_IDLE: if (cmd_fire) state_next = S_READ;
      S_READ: state_next = S_EXEC;
      S_EXEC: state_next = S_WB;
      S_WB:   state_next = cmd_fire ? S_READ : S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Writeback owns the port; Ld_Ready is already low whenever it is active.
    if (wb_active) begin
      WE       = 1'b1;
      WR       = rd_q;
      Mux_Ctrl = 1'b1;
    end else if (ld_fire) begin
      WE = 1'b1;
      WR = Ld_Addr;
      WD = Ld_Data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= S_IDLE;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      shamt_q     <= '0;
      wben_q      <= 1'b0;
      Done_Result <= '0;
      Done_Zero   <= 1'b0;
      Done_Err    <= 1'b0;
    end else begin
      state <= state_next;
      if (cmd_fire) begin
        op_q    <= Cmd_Op;
        rs_q    <= Cmd_Rs;
        rt_q    <= Cmd_Rt;
        rd_q    <= Cmd_Rd;
        shamt_q <= Cmd_Shamt;
        wben_q  <= Cmd_WbEn;
      end
      if (state == S_EXEC) begin
        Done_Result <= op_legal ? Alu_Result : '0;
        Done_Zero   <= Alu_Zero;
        Done_Err    <= !op_legal;
      end
    end
  end

`ifdef ALU_SEQ_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Op_Count <= '0;
    end else if (Op_Count_Clr) begin
      Op_Count <= '0;
    end else if (state == S_WB) begin
      Op_Count <= Op_Count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences the register file, the 2:1 write-data mux and the ALU to execute one register-register operation per command: read Rs/Rt, execute, write back to Rd.
- Also arbitrates the register file's single write port between ALU writeback and a host load port (direct data into a register).
- Sits between a command source (testbench or future decoder) and the existing RegisterFile, mux and ALU instances.

Parameters:
- DATA_W, 32, datapath width (register, ALU and load data)
- REG_AW, 5, register address width (32 registers)
- OP_W, 4, ALU opcode width

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- Cmd_Valid  in  1  command offered
- Cmd_Ready  out  1  command accepted when Cmd_Valid && Cmd_Ready at a rising edge
- Cmd_Op  in  OP_W  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 sra, 7 gt, 8 lt
- Cmd_Rs, Cmd_Rt, Cmd_Rd  in  REG_AW each  source A, source B and destination register
- Cmd_Shamt  in  5  shift count
- Cmd_WbEn  in  1  1 = write result to Rd
- Ld_Valid  in  1  host load request
- Ld_Ready  out  1  load accepted when Ld_Valid && Ld_Ready
- Ld_Addr  in  REG_AW  load destination register
- Ld_Data  in  DATA_W  load value
- RR1, RR2  out  REG_AW  register file read addresses
- WE  out  1  register file write enable
- WR  out  REG_AW  register file write address
- WD  out  DATA_W  load data, to mux input 0
- Mux_Ctrl  out  1  0 = load data, 1 = ALU result
- Alu_Op  out  OP_W  to ALU Op
- Alu_Shift  out  5  to ALU ShiftCount
- Alu_Result  in  DATA_W  ALU result
- Alu_Zero  in  1  ALU zero detect
- Busy  out  1  state != IDLE
- Done  out  1  one-cycle completion pulse
- Done_Result  out  DATA_W  latched result
- Done_Zero  out  1  latched zero flag
- Done_Err  out  1  latched illegal-opcode flag

Behaviour:
- Reset (Rst_n low, async): state IDLE; all outputs 0 (WE, WR, WD, Mux_Ctrl, RR1, RR2, Alu_Op, Alu_Shift, Busy, Done, Done_*). Cmd_Ready and Ld_Ready are 0 while Rst_n is low.
- Command fields are latched on acceptance. RR1 = Rs, RR2 = Rt, Alu_Op = Op and Alu_Shift = Shamt are held from READ through WB.
- States:
  - IDLE: Cmd_Ready = 1. On accept, go to READ.
  - READ: read addresses settle; go to EXEC.
  - EXEC: the ALU evaluates. At the closing edge, latch Alu_Result to Done_Result and Alu_Zero to Done_Zero. Done_Err is set to 1 if Op > 8. Go to WB.
  - WB: Done = 1. If WbEn and Op <= 8: WE = 1, WR = Rd, Mux_Ctrl = 1, so the write lands at the closing edge. Cmd_Ready = 1. On accept, go to READ; otherwise go to IDLE.
- Latency: accept edge to Done high = 3 cycles. Back-to-back throughput = 1 op per 3 cycles.
- Read-after-write: a command accepted in WB reads in the following READ and sees the just-written value. No bypass is needed.
- Illegal opcode (9–15): no writeback; Done_Result = 0; Done_Err = 1.
- Load port:
  - Ld_Ready = 0 during WB with writeback active.
  - Ld_Ready = 0 in READ/EXEC if Ld_Addr equals the latched Rs or Rt (operand protection).
  - Ld_Ready = 1 otherwise.
  - On load accept, in the same cycle: WE = 1, WR = Ld_Addr, WD = Ld_Data, Mux_Ctrl = 0. The register updates at that edge.
  - Writeback always has priority over a load.
- Loads to the latched Rd during READ/EXEC are allowed; the later writeback overwrites the loaded value.
- Simultaneous Cmd and Ld accept in IDLE: both are accepted. The load writes at that edge; the command reads the loaded value in READ.
- Reset mid-operation: the operation is abandoned, no writeback occurs, and no Done pulse is produced.
- WE, WR, WD and Mux_Ctrl are combinational from state and the load handshake. Done_* are registered.

Optional Feature:
- Macro: ALU_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output Op_Count (16 bits) and input Op_Count_Clr (1 bit).
  - Op_Count increments on every Done pulse and wraps 0xFFFF to 0.
  - Op_Count resets to 0 on Rst_n low, or synchronously when Op_Count_Clr = 1. Clear wins over a same-cycle increment.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Load -2 into r0 and 1200 into r1. Cmd add, Rs 0, Rt 1, Rd 5, WbEn = 1. Require: Done 3 cycles after accept; Done_Result = 1198; r5 = 1198 at the WB edge; Done_Zero = 0.
- Back-to-back: sub r6 = r5 - r5 accepted during WB. Require: Done_Result = 0, Done_Zero = 1, r6 = 0. Then sra r0 by 2: Done_Result = -1.
- Op = 12 with WbEn = 1. Require: Done_Err = 1, Done_Result = 0, WE never asserted, Rd unchanged.
- During EXEC of a command reading r1, hold Ld_Valid with Ld_Addr = 1. Require: Ld_Ready = 0 until WB ends. During WB with writeback active, Ld_Addr = 9: Ld_Ready = 0, then r9 is loaded the next cycle.
- Drop Rst_n in EXEC. Require: all outputs 0 immediately, no write to Rd, no Done pulse. After release, Cmd_Ready = 1 in IDLE.
- With ALU_SEQ_PERF_CNT_EN defined: 3 ops give Op_Count = 3. Op_Count_Clr asserted in a Done cycle gives Op_Count = 0.
